// File: rtl/idct_pkg.sv
// Shared IDCT constants, widths and types; also holds the Q11 cosine table used by idct_unit.
package idct_pkg;
   localparam int COEF_W    = 12;
   localparam int CONST_W   = 12;
   localparam int FRAC_BITS = 11;
   localparam int TERMS     = 8;
   localparam int OUT_W     = 8;

   function automatic int acc_width(input int coef_w, input int const_w, input int terms);
      return coef_w + const_w + $clog2(terms);
   endfunction

   localparam int ACC_W = acc_width(COEF_W, CONST_W, TERMS);
   localparam int CNT_W = $clog2(TERMS);
   localparam int R_W   = ACC_W - FRAC_BITS;

   typedef logic signed [COEF_W-1:0]  coef_t;
   typedef logic signed [CONST_W-1:0] const_t;
   typedef logic signed [ACC_W-1:0]   acc_t;
   typedef logic        [OUT_W-1:0]   pixel_t;

   typedef enum logic {ST_IDLE, ST_ACC} state_t;

   localparam acc_t ROUND_K = ACC_W'(1 << (FRAC_BITS - 1));

   // C(k) = cos(k*pi/16) in Q11, with C(0) carrying the 1/sqrt(2) DC normalisation.
   localparam const_t COS_Q11 [TERMS] = '{
      12'sd1448, 12'sd2009, 12'sd1892, 12'sd1703,
      12'sd1448, 12'sd1138, 12'sd784,  12'sd400
   };
endpackage

// File: rtl/idct_macu_if.sv
// Coefficient input stream and pixel output stream of one idct_macu.
interface idct_macu_if;
   import idct_pkg::*;

   logic   in_valid;
   logic   in_ready;
   coef_t  in_coef;
   const_t in_const;
   logic   out_valid;
   logic   out_ready;
   pixel_t out_pixel;
   logic   out_sat;

   modport master (
      output in_valid, in_coef, in_const, out_ready,
      input  in_ready, out_valid, out_pixel, out_sat
   );

   modport slave (
      input  in_valid, in_coef, in_const, out_ready,
      output in_ready, out_valid, out_pixel, out_sat
   );
endinterface

// File: rtl/idct_round_clamp.sv
// Rounds a Q11 accumulator sum to an integer sample and maps it to a pixel.
// IDCT_MACU_CLAMP_EN: level-shift by +128 and saturate to unsigned; otherwise wrap as signed.
module idct_round_clamp
   import idct_pkg::*;
(
   input  acc_t   sum,
   output pixel_t pixel,
   output logic   sat
);
   acc_t                   rounded;
   logic signed [R_W-1:0]  r;
   logic [FRAC_BITS-1:0]   unused_frac;

   // Taking the top bits after adding half an LSB is round-half-up with arithmetic shift.
   assign rounded     = sum + ROUND_K;
   assign r           = rounded[ACC_W-1:FRAC_BITS];
   assign unused_frac = rounded[FRAC_BITS-1:0];

`ifdef IDCT_MACU_CLAMP_EN
   logic signed [R_W:0] shifted;

   assign shifted = {r[R_W-1], r} + (R_W+1)'(1 << (OUT_W - 1));

   always_comb begin
      pixel = shifted[OUT_W-1:0];
      sat   = 1'b0;
      if (shifted[R_W]) begin
         pixel = '0;
         sat   = 1'b1;
      end else if (|shifted[R_W-1:OUT_W]) begin
         pixel = '1;
         sat   = 1'b1;
      end
   end
`else
   logic unused_hi;

   assign unused_hi = ^r[R_W-1:OUT_W];
   assign pixel     = r[OUT_W-1:0];
   assign sat       = 1'b0;
`endif
endmodule

// File: rtl/idct_macu.sv
// IDCT multiply-accumulate: sums TERMS coef*const products per pixel, rounds/maps the
// result and holds it on a valid/ready output. Output mapping selected by IDCT_MACU_CLAMP_EN.
module idct_macu
   import idct_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   idct_macu_if.slave     io
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   acc_t             acc_q, acc_d;
   logic             out_valid_q, out_valid_d;
   pixel_t           out_pixel_q, out_pixel_d;
   logic             out_sat_q, out_sat_d;

   acc_t   product;
   acc_t   sum;
   pixel_t rc_pixel;
   logic   rc_sat;
   logic   last_cnt;
   logic   in_ready;
   logic   beat;

   assign product  = ACC_W'(io.in_coef) * ACC_W'(io.in_const);
   assign sum      = ((state_q == ST_IDLE) ? '0 : acc_q) + product;
   assign last_cnt = (cnt_q == CNT_W'(TERMS - 1));
   // Only the closing beat needs the output slot, so only it can stall.
   assign in_ready = !(last_cnt && out_valid_q && !io.out_ready);
   assign beat     = io.in_valid && in_ready;

   idct_round_clamp u_round_clamp (
      .sum   (sum),
      .pixel (rc_pixel),
      .sat   (rc_sat)
   );

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_pixel_d = out_pixel_q;
      out_sat_d   = out_sat_q;

      if (out_valid_q && io.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (beat) begin
         if (last_cnt) begin
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_pixel_d = rc_pixel;
            out_sat_d   = rc_sat;
         end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = sum;
         end
      end

      state_d = (cnt_d == '0) ? ST_IDLE : ST_ACC;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign io.in_ready  = in_ready;
   assign io.out_valid = out_valid_q;
   assign io.out_pixel = out_pixel_q;
   assign io.out_sat   = out_sat_q;
endmodule

// File: tb/tb_idct_macu.sv
// Self-checking bench for idct_macu: directed cases then random-gap streaming vs a sum-of-products model.
module tb_idct_macu;
   import idct_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   idct_macu_if intf ();

   idct_macu dut (
      .clk (clk),
      .rst (rst),
      .io  (intf.slave)
   );

   always #5 clk = ~clk;

`ifdef IDCT_MACU_CLAMP_EN
   localparam logic [8:0] E1  = {1'b0, 8'd208};
   localparam logic [8:0] E2A = {1'b0, 8'd129};
   localparam logic [8:0] E2B = {1'b0, 8'd128};
   localparam logic [8:0] E3A = {1'b1, 8'd255};
   localparam logic [8:0] E3B = {1'b1, 8'd0};
   localparam logic [8:0] E5  = {1'b0, 8'd128};
`else
   localparam logic [8:0] E1  = {1'b0, 8'd80};
   localparam logic [8:0] E2A = {1'b0, 8'd1};
   localparam logic [8:0] E2B = {1'b0, 8'd0};
   localparam logic [8:0] E3A = {1'b0, 8'h20};
   localparam logic [8:0] E3B = {1'b0, 8'hE0};
   localparam logic [8:0] E5  = {1'b0, 8'd0};
`endif

   int          errors = 0;
   int          checks = 0;
   logic [8:0]  exp_q[$];
   longint      grp_acc = 0;
   int          grp_n = 0;
   bit          fired_in;
   bit          fired_out;
   logic [8:0]  last_out;
   int          n_produced = 0;
   int          n_drained = 0;
   int          stalls;

   // Spec-level result of one group: {sat, pixel}
   function automatic logic [8:0] ref_pixel(input longint s);
      longint r;
      r = (s + 1024) >>> 11;
`ifdef IDCT_MACU_CLAMP_EN
      begin
         longint v;
         v = r + 128;
         if (v < 0)   return {1'b1, 8'd0};
         if (v > 255) return {1'b1, 8'd255};
         return {1'b0, v[7:0]};
      end
`else
      return {1'b0, r[7:0]};
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: drive at negedge, check against model, then advance the model at posedge.
   task automatic step(input bit v, input int c, input int k, input bit rdy);
      coef_t  cs;
      const_t ks;
      @(negedge clk);
      cs = coef_t'(c);
      ks = const_t'(k);
      intf.in_valid  = v;
      intf.in_coef   = cs;
      intf.in_const  = ks;
      intf.out_ready = rdy;
      #1;
      chk("in_ready", 32'(intf.in_ready), 32'(!(grp_n == TERMS - 1 && exp_q.size() > 0 && !rdy)));
      chk("out_valid", 32'(intf.out_valid), 32'(exp_q.size() > 0));
      if (intf.out_valid === 1'b1 && exp_q.size() > 0)
         chk("out_pixel", 32'({intf.out_sat, intf.out_pixel}), 32'(exp_q[0]));
      fired_in  = v && (intf.in_ready === 1'b1);
      fired_out = rdy && (intf.out_valid === 1'b1);
      @(posedge clk);
      if (fired_out) begin
         last_out = {intf.out_sat, intf.out_pixel};
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         n_drained++;
      end
      if (fired_in) begin
         grp_acc += longint'(cs) * longint'(ks);
         grp_n++;
         if (grp_n == TERMS) begin
            exp_q.push_back(ref_pixel(grp_acc));
            n_produced++;
            grp_acc = 0;
            grp_n   = 0;
         end
      end
   endtask

   task automatic send_beat(input int c, input int k, input bit rdy);
      bit done = 0;
      for (int t = 0; t < 64 && !done; t++) begin
         step(1'b1, c, k, rdy);
         done = fired_in;
      end
      if (!done) chk("beat_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_group(input int c0, input int k0, input int c, input int k, input bit rdy);
      send_beat(c0, k0, rdy);
      for (int i = 1; i < TERMS; i++) send_beat(c, k, rdy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      intf.in_valid = 1'b0;
      @(posedge clk);
      exp_q.delete();
      grp_acc = 0;
      grp_n   = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(intf.out_valid), 32'd0);
      chk("rst_out_pixel", 32'(intf.out_pixel), 32'd0);
      chk("rst_out_sat", 32'(intf.out_sat), 32'd0);
      chk("rst_in_ready", 32'(intf.in_ready), 32'd1);
   endtask

   initial begin
      int cyc;
      intf.in_valid  = 1'b0;
      intf.in_coef   = '0;
      intf.in_const  = '0;
      intf.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // 1: unity-ish gain, latency checked by the per-cycle out_valid model
      send_group(20, 1024, 20, 1024, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("t1_pixel", 32'(last_out), 32'(E1));

      // 2: exact half rounds up; -half rounds to zero
      send_group(1, 1024, 0, 0, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("t2_half_up", 32'(last_out), 32'(E2A));
      send_group(-1, 1024, 0, 0, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("t2_neg_half", 32'(last_out), 32'(E2B));

      // 3: overflow in both directions
      send_group(200, 1024, 200, 1024, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("t3_high", 32'(last_out), 32'(E3A));
      send_group(-200, 1024, -200, 1024, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("t3_low", 32'(last_out), 32'(E3B));

      // 4: back-to-back with blocked output; final beat of group 2 stalls until drain
      send_group(3, 1448, 5, -784, 1'b0);
      for (int i = 1; i < TERMS; i++) send_beat(-7, 2009, 1'b0);
      stalls = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 9, 400, 1'b0);
         if (!fired_in) stalls++;
      end
      chk("t4_stalls", 32'(stalls), 32'd3);
      step(1'b1, 9, 400, 1'b1);
      chk("t4_accept_on_drain", 32'(fired_in && fired_out), 32'd1);
      step(1'b0, 0, 0, 1'b1);
      chk("t4_second_drained", 32'(exp_q.size()), 32'd0);

      // 5: reset discards pending pixel and partial group
      send_group(50, 1892, 50, 1892, 1'b0);
      for (int i = 0; i < 5; i++) send_beat(11, 1138, 1'b0);
      do_reset();
      send_group(0, 1703, 0, 1703, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("t5_pixel", 32'(last_out), 32'(E5));

      // 6: random traffic with gaps on both sides
      n_produced = 0;
      n_drained  = 0;
      cyc = 0;
      while (n_produced < 1000 && cyc < 40000) begin
         int c, k;
         c = int'($urandom_range(0, 4095)) - 2048;
         if ($urandom_range(0, 1) == 1) k = int'(COS_Q11[$urandom_range(0, TERMS - 1)]);
         else                           k = int'($urandom_range(0, 4095)) - 2048;
         if ($urandom_range(0, 7) < 2) c = c >>> 6;
         step($urandom_range(0, 3) != 0, c, k, $urandom_range(0, 3) != 0);
         cyc++;
      end
      chk("t6_groups_done", 32'(n_produced >= 1000), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b1);
      chk("t6_count", 32'(n_drained), 32'(n_produced));
      chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
